// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared channel indices and default sizing for int_ctrl
package int_ctrl_pkg;

   localparam int INT_COM             = 0;
   localparam int INT_KBD             = 1;
   localparam int INT_NUM_SRC_DEF     = 8;
   localparam int INT_ID_WIDTH        = 3;
   localparam int INT_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - one-bit multi-flop synchroniser for an asynchronous request line
module int_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         chain_q <= '0;
      end else begin
         chain_q[0] <= d_i;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            chain_q[k] <= chain_q[k-1];
         end
      end
   end

   assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller: sync, level/edge latch, mask, priority ID
// Optional lost-event flags under INT_CTRL_OVF_EN.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC     = INT_NUM_SRC_DEF,
   parameter int ID_W        = INT_ID_WIDTH,
   parameter int SYNC_STAGES = INT_SYNC_STAGES_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] int_req_raw,
   input  logic [NUM_SRC-1:0] edge_mode,
   input  logic [NUM_SRC-1:0] int_mask,
   input  logic               global_en,
   input  logic               ack,
   input  logic [ID_W-1:0]    ack_id,
`ifdef INT_CTRL_OVF_EN
   input  logic [NUM_SRC-1:0] ovf_clr,
   output logic [NUM_SRC-1:0] ovf,
`endif
   output logic [NUM_SRC-1:0] pending,
   output logic               has_int_pending,
   output logic [ID_W-1:0]    int_id,
   output logic               int_valid
);

   logic [NUM_SRC-1:0] sync_s;
   logic [NUM_SRC-1:0] prev_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] ack_hit;
   logic [NUM_SRC-1:0] active;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d_i (int_req_raw[g]),
         .q_o (sync_s[g])
      );
   end

   // Lowest index wins; returns 0 when nothing is active.
   function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
      prio_enc = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) prio_enc = ID_W'(i);
      end
   endfunction

   always_comb begin
      rise      = sync_s & ~prev_q;
      ack_hit   = '0;
      pending_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_hit[i] = ack && (int'(ack_id) == i);
         // A rise arriving with the ack re-latches, so the new event survives.
         if (edge_mode[i]) pending_d[i] = rise[i] | (pending_q[i] & ~ack_hit[i]);
         else              pending_d[i] = sync_s[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_q    <= '0;
         pending_q <= '0;
      end else begin
         prev_q    <= sync_s;
         pending_q <= pending_d;
      end
   end

`ifdef INT_CTRL_OVF_EN
   logic [NUM_SRC-1:0] ovf_q, ovf_d;

   always_comb begin
      ovf_d = (ovf_q & ~ovf_clr) | (edge_mode & rise & pending_q & ~ack_hit);
   end

   always_ff @(posedge clk) begin
      if (!rst) ovf_q <= '0;
      else      ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

   assign active          = pending_q & int_mask;
   assign pending         = pending_q;
   assign int_valid       = |active;
   assign has_int_pending = int_valid & global_en;
   assign int_id          = prio_enc(active);

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl (8-channel and 13-channel instances)
module tb_int_ctrl;
   import int_ctrl_pkg::*;

   localparam int SS   = 2;
   localparam int NA   = 8;
   localparam int IA   = 3;
   localparam int NB   = 13;
   localparam int IB   = 4;
   localparam int MAXC = 8192;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [NA-1:0] raw_a, em_a, mask_a, pend_a;
   logic          gen_a, ack_a, hip_a, val_a;
   logic [IA-1:0] aid_a, id_a;
   logic [NB-1:0] raw_b, em_b, mask_b, pend_b;
   logic          gen_b, ack_b, hip_b, val_b;
   logic [IB-1:0] aid_b, id_b;
`ifdef INT_CTRL_OVF_EN
   logic [NA-1:0] clr_a, ovf_a;
   logic [NB-1:0] clr_b, ovf_b;
`endif

   int_ctrl #(.NUM_SRC(NA), .ID_W(IA), .SYNC_STAGES(SS)) u_dut_a (
      .clk(clk), .rst(rst), .int_req_raw(raw_a), .edge_mode(em_a), .int_mask(mask_a),
      .global_en(gen_a), .ack(ack_a), .ack_id(aid_a),
`ifdef INT_CTRL_OVF_EN
      .ovf_clr(clr_a), .ovf(ovf_a),
`endif
      .pending(pend_a), .has_int_pending(hip_a), .int_id(id_a), .int_valid(val_a)
   );

   int_ctrl #(.NUM_SRC(NB), .ID_W(IB), .SYNC_STAGES(SS)) u_dut_b (
      .clk(clk), .rst(rst), .int_req_raw(raw_b), .edge_mode(em_b), .int_mask(mask_b),
      .global_en(gen_b), .ack(ack_b), .ack_id(aid_b),
`ifdef INT_CTRL_OVF_EN
      .ovf_clr(clr_b), .ovf(ovf_b),
`endif
      .pending(pend_b), .has_int_pending(hip_b), .int_id(id_b), .int_valid(val_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: s is simply the raw value seen SS edges ago (zero if that predates reset).
   logic [31:0] hist [2][MAXC];
   logic [31:0] m_pend [2];
   logic [31:0] m_prev [2];
   logic [31:0] m_ovf  [2];
   int          cyc      = 0;
   int          last_rst = 0;
   int          nsrc [2] = '{NA, NB};

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   function automatic int lowest(input logic [31:0] v);
      for (int i = 0; i < 32; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_edge();
      logic [31:0] raw [2], em [2], clr [2];
      logic [31:0] s, rise, np, novf;
      logic        ak [2];
      int          aid [2];
      logic        hit;
      raw[0] = 32'(raw_a); em[0] = 32'(em_a); ak[0] = ack_a; aid[0] = int'(aid_a);
      raw[1] = 32'(raw_b); em[1] = 32'(em_b); ak[1] = ack_b; aid[1] = int'(aid_b);
      clr[0] = '0; clr[1] = '0;
`ifdef INT_CTRL_OVF_EN
      clr[0] = 32'(clr_a); clr[1] = 32'(clr_b);
`endif
      cyc++;
      for (int d = 0; d < 2; d++) hist[d][cyc] = raw[d];
      if (!rst) begin
         last_rst = cyc;
         for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0; m_prev[d] = '0; m_ovf[d] = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            s    = (cyc - SS > last_rst) ? hist[d][cyc-SS] : 32'h0;
            rise = s & ~m_prev[d];
            np   = '0;
            novf = m_ovf[d];
            for (int i = 0; i < nsrc[d]; i++) begin
               hit = ak[d] && (aid[d] == i);
               if (em[d][i] && rise[i] && m_pend[d][i] && !hit) novf[i] = 1'b1;
               else if (clr[d][i])                               novf[i] = 1'b0;
               np[i] = em[d][i] ? (rise[i] || (m_pend[d][i] && !hit)) : s[i];
            end
            m_pend[d] = np;
            m_ovf[d]  = novf;
            m_prev[d] = s;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      logic [31:0] act;
      act = m_pend[0] & 32'(mask_a);
      check({tag, ".a.pend"}, 32'(pend_a), m_pend[0]);
      check({tag, ".a.valid"}, 32'(val_a), 32'(act != 0));
      check({tag, ".a.id"}, 32'(id_a), 32'(lowest(act)));
      check({tag, ".a.hip"}, 32'(hip_a), 32'((act != 0) && gen_a));
      act = m_pend[1] & 32'(mask_b);
      check({tag, ".b.pend"}, 32'(pend_b), m_pend[1]);
      check({tag, ".b.valid"}, 32'(val_b), 32'(act != 0));
      check({tag, ".b.id"}, 32'(id_b), 32'(lowest(act)));
      check({tag, ".b.hip"}, 32'(hip_b), 32'((act != 0) && gen_b));
`ifdef INT_CTRL_OVF_EN
      check({tag, ".a.ovf"}, 32'(ovf_a), m_ovf[0]);
      check({tag, ".b.ovf"}, 32'(ovf_b), m_ovf[1]);
`endif
   endtask

   typedef struct {
      logic [7:0] raw, em, mask;
      logic       gen, ack;
      logic [2:0] aid;
      logic [7:0] pend;
      logic       hip;
      logic [2:0] id;
      logic       val;
   } vec_t;

   vec_t tbl [16];

   initial begin
      tbl[0]  = '{8'h04, 8'h04, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[1]  = '{8'h00, 8'h04, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[2]  = '{8'h00, 8'h04, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h04, 1'b1, 3'd2, 1'b1};
      tbl[3]  = '{8'h00, 8'h04, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h04, 1'b1, 3'd2, 1'b1};
      tbl[4]  = '{8'h00, 8'h04, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[5]  = '{8'h22, 8'h26, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[6]  = '{8'h00, 8'h26, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[7]  = '{8'h00, 8'h26, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h22, 1'b1, 3'd1, 1'b1};
      tbl[8]  = '{8'h00, 8'h26, 8'hFF, 1'b1, 1'b1, 3'd1, 8'h20, 1'b1, 3'd5, 1'b1};
      tbl[9]  = '{8'h00, 8'h26, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[10] = '{8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[11] = '{8'h00, 8'h10, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[12] = '{8'h00, 8'h10, 8'h00, 1'b1, 1'b0, 3'd0, 8'h10, 1'b0, 3'd0, 1'b0};
      tbl[13] = '{8'h00, 8'h10, 8'h10, 1'b1, 1'b0, 3'd0, 8'h10, 1'b1, 3'd4, 1'b1};
      tbl[14] = '{8'h00, 8'h10, 8'h10, 1'b0, 1'b0, 3'd0, 8'h10, 1'b0, 3'd4, 1'b1};
      tbl[15] = '{8'h00, 8'h10, 8'h10, 1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 3'd0, 1'b0};

      rst = 1'b0;
      raw_a = '1; em_a = '0; mask_a = '1; gen_a = 1'b1; ack_a = 1'b0; aid_a = '0;
      raw_b = '1; em_b = '0; mask_b = '1; gen_b = 1'b1; ack_b = 1'b0; aid_b = '0;
`ifdef INT_CTRL_OVF_EN
      clr_a = '0; clr_b = '0;
`endif

      // Reset held with all lines high, then level channels appear SS+1 edges after release.
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst.a.pend", 32'(pend_a), 32'h0);
         check("rst.a.hip", 32'(hip_a), 32'h0);
         check("rst.a.id", 32'(id_a), 32'h0);
         check("rst.b.pend", 32'(pend_b), 32'h0);
      end
      rst = 1'b1;
      tick(); check("rel1.a.pend", 32'(pend_a), 32'h0);
      tick(); check("rel2.a.pend", 32'(pend_a), 32'h0);
      tick(); check("rel3.a.pend", 32'(pend_a), 32'hFF);
      check("rel3.b.pend", 32'(pend_b), 32'h1FFF);
      check("rel3.a.id", 32'(id_a), 32'h0);
      check("rel3.a.hip", 32'(hip_a), 32'h1);

      raw_a = '0; raw_b = '0;
      for (int k = 0; k < 4; k++) tick();
      check_model("settle");

      foreach (tbl[j]) begin
         raw_a = tbl[j].raw; em_a = tbl[j].em; mask_a = tbl[j].mask; gen_a = tbl[j].gen;
         ack_a = tbl[j].ack; aid_a = tbl[j].aid;
         tick();
         check($sformatf("tbl%0d.pend", j), 32'(pend_a), 32'(tbl[j].pend));
         check($sformatf("tbl%0d.hip", j), 32'(hip_a), 32'(tbl[j].hip));
         check($sformatf("tbl%0d.id", j), 32'(id_a), 32'(tbl[j].id));
         check($sformatf("tbl%0d.valid", j), 32'(val_a), 32'(tbl[j].val));
      end
      ack_a = 1'b0; gen_a = 1'b1; mask_a = '1;

      // Channel 3: ack coincides with a fresh rise, then a rise lands on an un-acked latch.
      em_a = 8'h08;
      raw_a = 8'h08; tick(); raw_a = 8'h00; tick(); tick();
      check("ch3.first.pend", 32'(pend_a), 32'h08);
      raw_a = 8'h08; tick(); raw_a = 8'h00; tick();
      ack_a = 1'b1; aid_a = 3'd3; tick(); ack_a = 1'b0;
      check("ch3.ackrise.pend", 32'(pend_a), 32'h08);
`ifdef INT_CTRL_OVF_EN
      check("ch3.ackrise.ovf", 32'(ovf_a), 32'h00);
`endif
      raw_a = 8'h08; tick(); raw_a = 8'h00; tick(); tick();
      check("ch3.second.pend", 32'(pend_a), 32'h08);
`ifdef INT_CTRL_OVF_EN
      check("ch3.lost.ovf", 32'(ovf_a), 32'h08);
      clr_a = 8'h08; tick(); clr_a = '0;
      check("ch3.clr.ovf", 32'(ovf_a), 32'h00);
`endif
      ack_a = 1'b1; aid_a = 3'd3; tick(); ack_a = 1'b0;
      check("ch3.ack.pend", 32'(pend_a), 32'h00);

      // Wide instance: level channel 12 ignores ack; out-of-range ack leaves an edge latch alone.
      em_b = '0; mask_b = '1; raw_b = 13'h1000;
      tick(); tick(); tick();
      check("b12.id", 32'(id_b), 32'd12);
      check("b12.valid", 32'(val_b), 32'h1);
      ack_b = 1'b1; aid_b = 4'd12; tick(); ack_b = 1'b0;
      check("b12.ack.pend", 32'(pend_b), 32'h1000);
      raw_b = '0; tick(); tick();
      check("b12.low2.pend", 32'(pend_b), 32'h1000);
      tick();
      check("b12.low3.pend", 32'(pend_b), 32'h0);
      em_b = 13'h0001;
      raw_b = 13'h0001; tick(); raw_b = '0; tick(); tick();
      check("b0.pend", 32'(pend_b), 32'h1);
      ack_b = 1'b1; aid_b = 4'd13; tick();
      check("b.oor13.pend", 32'(pend_b), 32'h1);
      aid_b = 4'd15; tick();
      check("b.oor15.pend", 32'(pend_b), 32'h1);
      aid_b = 4'd0; tick(); ack_b = 1'b0;
      check("b0.ack.pend", 32'(pend_b), 32'h0);
      check_model("hand");

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] act;
         rst   = ($urandom_range(0, 499) != 0);
         raw_a = raw_a ^ NA'($urandom & $urandom & $urandom);
         raw_b = raw_b ^ NB'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 49) == 0) em_a = NA'($urandom);
         if ($urandom_range(0, 49) == 0) em_b = NB'($urandom);
         if ($urandom_range(0, 7) == 0) mask_a = NA'($urandom);
         if ($urandom_range(0, 7) == 0) mask_b = NB'($urandom);
         gen_a = ($urandom_range(0, 3) != 0);
         gen_b = ($urandom_range(0, 3) != 0);
         act   = m_pend[0] & 32'(mask_a);
         ack_a = ($urandom_range(0, 2) == 0);
         aid_a = ($urandom_range(0, 9) < 7) ? IA'(lowest(act)) : IA'($urandom);
         act   = m_pend[1] & 32'(mask_b);
         ack_b = ($urandom_range(0, 2) == 0);
         aid_b = ($urandom_range(0, 9) < 7) ? IB'(lowest(act)) : IB'($urandom);
`ifdef INT_CTRL_OVF_EN
         clr_a = NA'($urandom & $urandom & $urandom);
         clr_b = NB'($urandom & $urandom & $urandom);
`endif
         tick();
         check_model($sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
